// File: rtl/pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control_unit
// Purpose  : RV32I ID-stage decode, control pipeline (ID/EX, EX/MEM, MEM/WB),
//            hazard stall and branch flush. Optional macro FORWARDING_EN.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  illegal,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic                  mem_mem_2_reg,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_2_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  localparam logic [1:0] c_ALU_ADD   = 2'b00;
  localparam logic [1:0] c_ALU_SUB   = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT = 2'b10;

  localparam logic [1:0] c_FWD_RF    = 2'b00;
  localparam logic [1:0] c_FWD_WB    = 2'b01;
  localparam logic [1:0] c_FWD_MEM   = 2'b10;

  logic       w_known, w_use_rs1, w_use_rs2;
  logic       w_alu_src, w_mem_2_reg, w_reg_write, w_mem_read, w_mem_write;
  logic       w_branch, w_jump;
  logic [1:0] w_alu_op;

  always_comb begin
    w_known     = 1'b1;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_alu_src   = 1'b0;
    w_mem_2_reg = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_alu_op    = c_ALU_ADD;
    case (id_opcode)
      c_OP_R: begin
        w_reg_write = 1'b1; w_alu_op = c_ALU_FUNCT;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      c_OP_I: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = c_ALU_FUNCT;
        w_use_rs1 = 1'b1;
      end
      c_OP_LOAD: begin
        w_alu_src = 1'b1; w_mem_2_reg = 1'b1; w_reg_write = 1'b1;
        w_mem_read = 1'b1; w_use_rs1 = 1'b1;
      end
      c_OP_STORE: begin
        w_alu_src = 1'b1; w_mem_write = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      c_OP_BRANCH: begin
        w_branch = 1'b1; w_alu_op = c_ALU_SUB;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      c_OP_JAL: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_jump = 1'b1;
      end
      c_OP_JALR: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_jump = 1'b1;
        w_use_rs1 = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  assign illegal     = id_valid & ~w_known;
  assign flush_if_id = ex_redirect;

  logic                  r_ex_valid, r_ex_alu_src, r_ex_branch, r_ex_jump;
  logic                  r_ex_mem_read, r_ex_mem_write, r_ex_reg_write, r_ex_mem_2_reg;
  logic [1:0]            r_ex_alu_op;
  logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic                  r_mem_valid, r_mem_mem_read, r_mem_mem_write;
  logic                  r_mem_reg_write, r_mem_mem_2_reg;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_valid, r_wb_reg_write, r_wb_mem_2_reg;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  // x0 sources never hazard; a matching producer rd is therefore nonzero too.
  logic w_chk_rs1, w_chk_rs2, w_raw_rs1, w_raw_rs2, w_hazard, w_bubble;
  assign w_chk_rs1 = w_use_rs1 & (id_rs1 != '0);
  assign w_chk_rs2 = w_use_rs2 & (id_rs2 != '0);

`ifdef FORWARDING_EN
  assign w_raw_rs1 = r_ex_valid & r_ex_mem_read & (r_ex_rd == id_rs1);
  assign w_raw_rs2 = r_ex_valid & r_ex_mem_read & (r_ex_rd == id_rs2);
`else
  // Without bypass paths any in-flight producer in EX or MEM must drain;
  // the register file writes before it reads, so WB is already visible.
  assign w_raw_rs1 = (r_ex_valid  & r_ex_reg_write  & (r_ex_rd  == id_rs1)) |
                     (r_mem_valid & r_mem_reg_write & (r_mem_rd == id_rs1));
  assign w_raw_rs2 = (r_ex_valid  & r_ex_reg_write  & (r_ex_rd  == id_rs2)) |
                     (r_mem_valid & r_mem_reg_write & (r_mem_rd == id_rs2));
`endif

  assign w_hazard = id_valid & ((w_chk_rs1 & w_raw_rs1) | (w_chk_rs2 & w_raw_rs2));
  assign stall    = w_hazard & ~ex_redirect;
  assign w_bubble = ex_redirect | w_hazard | ~w_known;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_alu_src   <= 1'b0;
      r_ex_branch    <= 1'b0;
      r_ex_jump      <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_2_reg <= 1'b0;
      r_ex_alu_op    <= c_ALU_ADD;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
    end else begin
      r_ex_valid     <= id_valid    & ~w_bubble;
      r_ex_alu_src   <= w_alu_src   & ~w_bubble;
      r_ex_branch    <= w_branch    & ~w_bubble;
      r_ex_jump      <= w_jump      & ~w_bubble;
      r_ex_mem_read  <= w_mem_read  & ~w_bubble;
      r_ex_mem_write <= w_mem_write & ~w_bubble;
      r_ex_reg_write <= w_reg_write & ~w_bubble;
      r_ex_mem_2_reg <= w_mem_2_reg & ~w_bubble;
      r_ex_alu_op    <= w_bubble ? c_ALU_ADD : w_alu_op;
      r_ex_rs1       <= w_bubble ? '0 : id_rs1;
      r_ex_rs2       <= w_bubble ? '0 : id_rs2;
      r_ex_rd        <= w_bubble ? '0 : id_rd;
    end
  end

  // The redirecting branch/jump sits in EX and must still retire, so EX/MEM
  // is never squashed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mem_valid     <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_mem_mem_write <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_2_reg <= 1'b0;
      r_mem_rd        <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_2_reg  <= 1'b0;
      r_wb_rd         <= '0;
    end else begin
      r_mem_valid     <= r_ex_valid;
      r_mem_mem_read  <= r_ex_mem_read;
      r_mem_mem_write <= r_ex_mem_write;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_mem_2_reg <= r_ex_mem_2_reg;
      r_mem_rd        <= r_ex_rd;
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_mem_2_reg  <= r_mem_mem_2_reg;
      r_wb_rd         <= r_mem_rd;
    end
  end

`ifdef FORWARDING_EN
  logic w_mem_fwd_ok, w_wb_fwd_ok;
  assign w_mem_fwd_ok = r_mem_valid & r_mem_reg_write & (r_mem_rd != '0);
  assign w_wb_fwd_ok  = r_wb_valid  & r_wb_reg_write  & (r_wb_rd  != '0);

  assign fwd_a = (w_mem_fwd_ok & (r_mem_rd == r_ex_rs1)) ? c_FWD_MEM :
                 (w_wb_fwd_ok  & (r_wb_rd  == r_ex_rs1)) ? c_FWD_WB  : c_FWD_RF;
  assign fwd_b = (w_mem_fwd_ok & (r_mem_rd == r_ex_rs2)) ? c_FWD_MEM :
                 (w_wb_fwd_ok  & (r_wb_rd  == r_ex_rs2)) ? c_FWD_WB  : c_FWD_RF;
`else
  assign fwd_a = c_FWD_RF;
  assign fwd_b = c_FWD_RF;
`endif

  assign ex_valid      = r_ex_valid;
  assign ex_alu_src    = r_ex_alu_src;
  assign ex_branch     = r_ex_branch;
  assign ex_jump       = r_ex_jump;
  assign ex_alu_op     = r_ex_alu_op;
  assign ex_rs1        = r_ex_rs1;
  assign ex_rs2        = r_ex_rs2;
  assign ex_rd         = r_ex_rd;
  assign mem_valid     = r_mem_valid;
  assign mem_mem_read  = r_mem_mem_read;
  assign mem_mem_write = r_mem_mem_write;
  assign mem_reg_write = r_mem_reg_write;
  assign mem_mem_2_reg = r_mem_mem_2_reg;
  assign mem_rd        = r_mem_rd;
  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_mem_2_reg  = r_wb_mem_2_reg;
  assign wb_rd         = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control_unit
// Purpose  : Directed self-checking bench for pipe_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect;
    logic       stall, flush_if_id, illegal;
    logic       ex_valid, ex_alu_src, ex_branch, ex_jump;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_2_reg;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_reg_write, wb_mem_2_reg;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_control_unit #(.REG_ADDR_W(5)) dut (
        .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .flush_if_id(flush_if_id), .illegal(illegal),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
        .mem_mem_2_reg(mem_mem_2_reg), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_2_reg(wb_mem_2_reg), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setid(input logic v, input logic [6:0] op,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        #1;
    endtask

    task automatic drain;
        setid(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    // {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, jump, alu_op}
    logic [6:0] ops [8];
    logic [8:0] ctl [8];
    logic [4:0] exp_rd;
    logic [1:0] exp_fwd;

    initial begin
        #100000;
        $error("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'h7F};
        ctl = '{9'b001000010, 9'b101000010, 9'b111100000, 9'b100010000,
                9'b000001001, 9'b101000100, 9'b101000100, 9'b000000000};

        arst_n = 1'b0;
        ex_redirect = 1'b0;
        setid(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd9);
        repeat (2) tick();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_alu_op", ex_alu_op, 2'b00);
        chk("rst_ex_rd", ex_rd, 5'd0);
        chk("rst_mem_reg_write", mem_reg_write, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        arst_n = 1'b1;
        tick();
        chk("post_rst_ex_valid", ex_valid, 1'b1);
        chk("post_rst_ex_alu_op", ex_alu_op, 2'b10);
        chk("post_rst_mem_reg_write", mem_reg_write, 1'b0);

        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                setid(1'b1, ops[i], 5'd1, 5'd2, 5'(10 + i));
                n_checks++;
                if (illegal !== (i == 7)) begin
                    n_fail++;
                    $error("FAIL stream_illegal i=%0d observed=%0h", i, illegal);
                end
                n_checks++;
                if (stall !== 1'b0) begin
                    n_fail++;
                    $error("FAIL stream_stall i=%0d observed=%0h", i, stall);
                end
            end else begin
                setid(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
            end
            tick();
            if (i < 8) begin
                exp_rd = (i == 7) ? 5'd0 : 5'(10 + i);
                n_checks++;
                if (ex_valid !== (i != 7)) begin
                    n_fail++;
                    $error("FAIL stream_ex_valid i=%0d observed=%0h", i, ex_valid);
                end
                n_checks++;
                if (ex_alu_src !== ctl[i][8]) begin
                    n_fail++;
                    $error("FAIL stream_ex_alu_src i=%0d observed=%0h", i, ex_alu_src);
                end
                n_checks++;
                if (ex_branch !== ctl[i][3]) begin
                    n_fail++;
                    $error("FAIL stream_ex_branch i=%0d observed=%0h", i, ex_branch);
                end
                n_checks++;
                if (ex_jump !== ctl[i][2]) begin
                    n_fail++;
                    $error("FAIL stream_ex_jump i=%0d observed=%0h", i, ex_jump);
                end
                n_checks++;
                if (ex_alu_op !== ctl[i][1:0]) begin
                    n_fail++;
                    $error("FAIL stream_ex_alu_op i=%0d observed=%0h", i, ex_alu_op);
                end
                n_checks++;
                if (ex_rd !== exp_rd) begin
                    n_fail++;
                    $error("FAIL stream_ex_rd i=%0d observed=%0h", i, ex_rd);
                end
            end
            if (i > 0) begin
                n_checks++;
                if (mem_valid !== (i - 1 != 7)) begin
                    n_fail++;
                    $error("FAIL stream_mem_valid i=%0d observed=%0h", i, mem_valid);
                end
                n_checks++;
                if (mem_mem_2_reg !== ctl[i-1][7]) begin
                    n_fail++;
                    $error("FAIL stream_mem_2_reg i=%0d observed=%0h", i, mem_mem_2_reg);
                end
                n_checks++;
                if (mem_reg_write !== ctl[i-1][6]) begin
                    n_fail++;
                    $error("FAIL stream_mem_reg_write i=%0d observed=%0h", i, mem_reg_write);
                end
                n_checks++;
                if (mem_mem_read !== ctl[i-1][5]) begin
                    n_fail++;
                    $error("FAIL stream_mem_read i=%0d observed=%0h", i, mem_mem_read);
                end
                n_checks++;
                if (mem_mem_write !== ctl[i-1][4]) begin
                    n_fail++;
                    $error("FAIL stream_mem_write i=%0d observed=%0h", i, mem_mem_write);
                end
            end
        end
        drain();

        setid(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        chk("lu_first_stall", stall, 1'b0);
        tick();
        setid(1'b1, 7'b0110011, 5'd5, 5'd7, 5'd6);
        chk("lu_stall_1", stall, 1'b1);
        tick();
        chk("lu_ex_bubble", ex_valid, 1'b0);
        chk("lu_mem_load", mem_mem_read, 1'b1);
`ifdef FORWARDING_EN
        chk("lu_stall_2", stall, 1'b0);
        exp_fwd = 2'b01;
`else
        chk("lu_stall_2", stall, 1'b1);
        tick();
        chk("lu_ex_bubble_2", ex_valid, 1'b0);
        chk("lu_stall_3", stall, 1'b0);
        exp_fwd = 2'b00;
`endif
        tick();
        chk("lu_add_ex_valid", ex_valid, 1'b1);
        chk("lu_add_ex_rd", ex_rd, 5'd6);
        chk("lu_fwd_a", fwd_a, exp_fwd);
        chk("lu_fwd_b", fwd_b, 2'b00);
        drain();

        setid(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd3);
        tick();
        setid(1'b1, 7'b0110011, 5'd3, 5'd3, 5'd4);
`ifdef FORWARDING_EN
        chk("raw_stall", stall, 1'b0);
`else
        chk("raw_stall_1", stall, 1'b1);
        tick();
        chk("raw_ex_bubble_1", ex_valid, 1'b0);
        chk("raw_stall_2", stall, 1'b1);
        tick();
        chk("raw_ex_bubble_2", ex_valid, 1'b0);
        chk("raw_stall_3", stall, 1'b0);
`endif
        tick();
        chk("raw_sub_ex_rd", ex_rd, 5'd4);
`ifdef FORWARDING_EN
        chk("raw_fwd_a", fwd_a, 2'b10);
        chk("raw_fwd_b", fwd_b, 2'b10);
`else
        chk("raw_fwd_a", fwd_a, 2'b00);
        chk("raw_fwd_b", fwd_b, 2'b00);
`endif
        drain();

        setid(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        tick();
        setid(1'b1, 7'b0000011, 5'd5, 5'd0, 5'd5);
        ex_redirect = 1'b1;
        #1;
        chk("redir_flush", flush_if_id, 1'b1);
        chk("redir_stall", stall, 1'b0);
        tick();
        ex_redirect = 1'b0;
        #1;
        chk("redir_flush_off", flush_if_id, 1'b0);
        chk("redir_ex_valid", ex_valid, 1'b0);
        chk("redir_mem_valid", mem_valid, 1'b1);
        chk("redir_mem_rd", mem_rd, 5'd5);
        drain();

        setid(1'b1, 7'b0000011, 5'd0, 5'd0, 5'd0);
        tick();
        setid(1'b1, 7'b0110011, 5'd0, 5'd0, 5'd1);
        chk("x0_stall", stall, 1'b0);
        tick();
        chk("x0_ex_valid", ex_valid, 1'b1);
        chk("x0_fwd_a", fwd_a, 2'b00);
        chk("x0_fwd_b", fwd_b, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
